// File: rtl/vlc_ook_tx.sv
// Manchester/OOK frame serialiser fed from the read port of an async FIFO.
// Frame = PRE_BYTES x 8'h55 preamble, SFD, payload bytes popped on the fly, then an LED-off gap.
module vlc_ook_tx #(
    parameter int         CLK_DIV   = 16,
    parameter int         PRE_BYTES = 4,
    parameter logic [7:0] SFD       = 8'hD5,
    parameter int         MAX_LEN   = 64,
    parameter int         GAP_BITS  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       rempty,
    input  logic [7:0] rdata,
    output logic       rinc,
    output logic       led,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_len
);
    localparam int GAP_CHIPS = 2 * GAP_BITS;
    localparam int GW        = (GAP_CHIPS > 1) ? $clog2(GAP_CHIPS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRE, S_SFD, S_DATA, S_GAP} state_t;

    state_t         state;
    logic [15:0]    div_cnt;
    logic [3:0]     chip_idx;
    logic [3:0]     pre_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [7:0]     cur_byte;
    logic [7:0]     nxt_byte;
    logic [7:0]     byte_cnt;
    logic           nxt_valid;
    logic           pend;
    logic           tick;

    assign tick = (div_cnt == 16'(CLK_DIV - 1));

    // Chip c of a byte: even chips carry the bit, odd chips its complement (MSB first).
    function automatic logic chip_of(input logic [7:0] b, input logic [3:0] c);
        return b[~c[3:1]] ^ c[0];
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            chip_idx   <= '0;
            pre_cnt    <= '0;
            gap_cnt    <= '0;
            cur_byte   <= '0;
            nxt_byte   <= '0;
            byte_cnt   <= '0;
            nxt_valid  <= 1'b0;
            pend       <= 1'b0;
            rinc       <= 1'b0;
            led        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
        end else begin
            rinc       <= 1'b0;
            frame_done <= 1'b0;
            pend       <= rinc;
            // rdata is valid the cycle after a pop; the LOAD pop already counted as byte 1
            if (pend) begin
                nxt_byte  <= rdata;
                nxt_valid <= 1'b1;
                if (state == S_DATA)
                    byte_cnt <= byte_cnt + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    led <= 1'b0;
                    if (enable && !rempty) begin
                        rinc  <= 1'b1;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    byte_cnt <= 8'd1;
                    cur_byte <= 8'h55;
                    pre_cnt  <= '0;
                    chip_idx <= '0;
                    div_cnt  <= '0;
                    led      <= chip_of(8'h55, 4'd0);
                    state    <= S_PRE;
                end
                S_GAP: begin
                    div_cnt <= tick ? '0 : div_cnt + 16'd1;
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_CHIPS - 1)) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            frame_len  <= byte_cnt;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: begin
                    div_cnt <= tick ? '0 : div_cnt + 16'd1;
                    if (tick) begin
                        if (chip_idx != 4'd15) begin
                            chip_idx <= chip_idx + 4'd1;
                            led      <= chip_of(cur_byte, chip_idx + 4'd1);
                            // Prefetch on entering the first chip of the LSB
                            if (state == S_DATA && chip_idx == 4'd13 && !rempty &&
                                byte_cnt < 8'(MAX_LEN))
                                rinc <= 1'b1;
                        end else begin
                            chip_idx <= '0;
                            case (state)
                                S_PRE: begin
                                    if (pre_cnt == 4'(PRE_BYTES - 1)) begin
                                        cur_byte <= SFD;
                                        led      <= chip_of(SFD, 4'd0);
                                        state    <= S_SFD;
                                    end else begin
                                        pre_cnt <= pre_cnt + 4'd1;
                                        led     <= chip_of(8'h55, 4'd0);
                                    end
                                end
                                S_SFD: begin
                                    cur_byte  <= nxt_byte;
                                    nxt_valid <= 1'b0;
                                    led       <= chip_of(nxt_byte, 4'd0);
                                    state     <= S_DATA;
                                end
                                default: begin
                                    if (nxt_valid) begin
                                        cur_byte  <= nxt_byte;
                                        nxt_valid <= 1'b0;
                                        led       <= chip_of(nxt_byte, 4'd0);
                                    end else begin
                                        led     <= 1'b0;
                                        gap_cnt <= '0;
                                        state   <= S_GAP;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vlc_ook_tx.sv
// Directed self-checking bench for vlc_ook_tx with behavioural FIFO read ports.
// Two instances: MAX_LEN=64 for the main scenarios, MAX_LEN=3 for the byte-limit split.
module tb_vlc_ook_tx;
    localparam int CLK_DIV   = 2;
    localparam int PRE_BYTES = 2;
    localparam int GAP_BITS  = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable_a, rempty_a, rinc_a, led_a, busy_a, frame_done_a;
    logic [7:0] rdata_a, frame_len_a;
    logic       enable_b, rempty_b, rinc_b, led_b, busy_b, frame_done_b;
    logic [7:0] rdata_b, frame_len_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vlc_ook_tx #(.CLK_DIV(CLK_DIV), .PRE_BYTES(PRE_BYTES), .SFD(8'hD5), .MAX_LEN(64), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .resetn(resetn), .enable(enable_a), .rempty(rempty_a), .rdata(rdata_a),
        .rinc(rinc_a), .led(led_a), .busy(busy_a), .frame_done(frame_done_a), .frame_len(frame_len_a));

    vlc_ook_tx #(.CLK_DIV(CLK_DIV), .PRE_BYTES(PRE_BYTES), .SFD(8'hD5), .MAX_LEN(3), .GAP_BITS(GAP_BITS)) dut_lim (
        .clk(clk), .resetn(resetn), .enable(enable_b), .rempty(rempty_b), .rdata(rdata_b),
        .rinc(rinc_b), .led(led_b), .busy(busy_b), .frame_done(frame_done_b), .frame_len(frame_len_b));

    // FIFO read ports with a 1-cycle registered read
    logic [7:0] mem_a[64];
    logic [7:0] mem_b[64];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    assign rempty_a = (wr_a == rd_a);
    assign rempty_b = (wr_b == rd_b);

    always @(posedge clk) begin
        if (rinc_a && !rempty_a) begin
            rdata_a <= mem_a[rd_a % 64];
            rd_a    <= rd_a + 1;
        end
        if (rinc_b && !rempty_b) begin
            rdata_b <= mem_b[rd_b % 64];
            rd_b    <= rd_b + 1;
        end
    end

    // Per-cycle record of led while busy, plus pop positions within that record
    logic trace_a[$];
    logic trace_b[$];
    int   rinc_at_a[$];
    int   rinc_cnt_a = 0, rinc_cnt_b = 0, empty_pop = 0;

    always @(negedge clk) begin
        if (busy_a) begin
            trace_a.push_back(led_a);
            if (rinc_a) rinc_at_a.push_back(trace_a.size() - 1);
        end
        if (busy_b) trace_b.push_back(led_b);
        if (rinc_a) rinc_cnt_a++;
        if (rinc_b) rinc_cnt_b++;
        if ((rinc_a && rempty_a) || (rinc_b && rempty_b)) empty_pop++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] v);
        if (sel) begin
            mem_b[wr_b % 64] = v;
            wr_b++;
        end else begin
            mem_a[wr_a % 64] = v;
            wr_a++;
        end
    endtask

    task automatic wait_done(input string tag, input bit sel, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = sel ? frame_done_b : frame_done_a;
        end
        checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_trace(input string tag, input int target, input int budget);
        bit reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            @(negedge clk);
            reached = (trace_a.size() >= target);
        end
        checkOutput({tag, "_reach"}, 32'(reached), 32'd1);
    endtask

    // Builds the expected led record (LOAD cycle, chips, gap) and compares it element-wise
    task automatic check_trace(input string tag, input bit sel, input int start, input logic [39:0] payload, input int n);
        logic       exp_q[$];
        logic [7:0] b;
        logic       got;
        int         nbad = 0;
        int         sz;
        exp_q.push_back(1'b0);
        for (int k = 0; k < PRE_BYTES + 1 + n; k++) begin
            if (k < PRE_BYTES) b = 8'h55;
            else if (k == PRE_BYTES) b = 8'hD5;
            else b = payload[8*(n - 1 - (k - PRE_BYTES - 1)) +: 8];
            for (int j = 7; j >= 0; j--) begin
                repeat (CLK_DIV) exp_q.push_back(b[j]);
                repeat (CLK_DIV) exp_q.push_back(~b[j]);
            end
        end
        repeat (GAP_BITS * 2 * CLK_DIV) exp_q.push_back(1'b0);
        sz = sel ? trace_b.size() : trace_a.size();
        checkOutput({tag, "_len"}, 32'(sz - start), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i >= sz) nbad++;
            else begin
                got = sel ? trace_b[start + i] : trace_a[start + i];
                if (got !== exp_q[i]) nbad++;
            end
        end
        checkOutput({tag, "_chips"}, 32'(nbad), 32'd0);
    endtask

    initial begin
        int start, cnt0, rbase, pos;
        resetn   = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_led", led_a, 0);
        checkOutput("rst_rinc", rinc_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", frame_done_a, 0);
        checkOutput("rst_len", frame_len_a, 0);
        resetn = 1'b1;

        $display("[TB] enable low with data waiting, then single byte A5");
        applyStimulus(0, 8'hA5);
        cnt0 = rinc_cnt_a;
        repeat (10) @(negedge clk);
        checkOutput("idle_rinc", 32'(rinc_cnt_a - cnt0), 0);
        checkOutput("idle_busy", busy_a, 0);
        checkOutput("idle_led", led_a, 0);
        start = trace_a.size();
        enable_a = 1'b1;
        @(negedge clk);
        checkOutput("start_busy", busy_a, 1);
        checkOutput("start_rinc", rinc_a, 1);
        wait_done("t1", 0, 400);
        check_trace("t1", 0, start, 40'hA5, 1);
        checkOutput("t1_first_chips", {trace_a[start+1], trace_a[start+3], trace_a[start+5], trace_a[start+7]}, 4'b0110);
        checkOutput("t1_rinc_cnt", 32'(rinc_cnt_a - cnt0), 1);
        checkOutput("t1_frame_len", frame_len_a, 1);
        checkOutput("t1_busy_fall", busy_a, 0);
        @(negedge clk);
        checkOutput("t1_done_pulse", frame_done_a, 0);

        $display("[TB] five bytes, enable dropped mid-frame");
        enable_a = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i));
        @(negedge clk);
        start = trace_a.size();
        rbase = rinc_at_a.size();
        cnt0  = rinc_cnt_a;
        enable_a = 1'b1;
        repeat (150) @(negedge clk);
        enable_a = 1'b0;
        wait_done("t2", 0, 600);
        check_trace("t2", 0, start, 40'h0102030405, 5);
        checkOutput("t2_rinc_cnt", 32'(rinc_cnt_a - cnt0), 5);
        checkOutput("t2_frame_len", frame_len_a, 5);
        for (int k = 0; k < 5; k++) begin
            pos = (rbase + k < rinc_at_a.size()) ? rinc_at_a[rbase + k] - start : -1;
            checkOutput($sformatf("t2_rinc_at%0d", k), 32'(pos),
                        (k == 0) ? 32'd0 : 32'(1 + ((PRE_BYTES + k) * 16 + 14) * CLK_DIV));
        end

        $display("[TB] data arrives during gap");
        start = trace_a.size();
        cnt0  = rinc_cnt_a;
        applyStimulus(0, 8'h3C);
        enable_a = 1'b1;
        wait_trace("t6", start + 150, 400);
        applyStimulus(0, 8'h7E);
        wait_done("t6a", 0, 400);
        check_trace("t6a", 0, start, 40'h3C, 1);
        checkOutput("t6a_rinc_cnt", 32'(rinc_cnt_a - cnt0), 1);
        checkOutput("t6a_frame_len", frame_len_a, 1);
        start = trace_a.size();
        cnt0  = rinc_cnt_a;
        @(negedge clk);
        checkOutput("t6b_restart_busy", busy_a, 1);
        wait_done("t6b", 0, 400);
        check_trace("t6b", 0, start, 40'h7E, 1);
        checkOutput("t6b_rinc_cnt", 32'(rinc_cnt_a - cnt0), 1);
        enable_a = 1'b0;

        $display("[TB] reset during DATA");
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
        start = trace_a.size();
        enable_a = 1'b1;
        wait_trace("t5", start + 120, 400);
        checkOutput("t5_pre_led", led_a, 1);
        resetn = 1'b0;
        #1;
        checkOutput("t5_rst_led", led_a, 0);
        checkOutput("t5_rst_busy", busy_a, 0);
        checkOutput("t5_rst_rinc", rinc_a, 0);
        checkOutput("t5_rst_done", frame_done_a, 0);
        checkOutput("t5_rst_len", frame_len_a, 0);
        enable_a = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        cnt0 = rinc_cnt_a;
        repeat (6) @(negedge clk);
        checkOutput("t5_hold_busy", busy_a, 0);
        checkOutput("t5_hold_rinc", 32'(rinc_cnt_a - cnt0), 0);
        start = trace_a.size();
        enable_a = 1'b1;
        wait_done("t5", 0, 600);
        check_trace("t5", 0, start, 40'h2233, 2);
        checkOutput("t5_frame_len", frame_len_a, 2);
        enable_a = 1'b0;

        $display("[TB] byte limit splits five bytes into 3 + 2");
        for (int i = 1; i <= 5; i++) applyStimulus(1, 8'(i));
        start = trace_b.size();
        cnt0  = rinc_cnt_b;
        enable_b = 1'b1;
        wait_done("t3a", 1, 800);
        check_trace("t3a", 1, start, 40'h010203, 3);
        checkOutput("t3a_frame_len", frame_len_b, 3);
        checkOutput("t3a_rinc_cnt", 32'(rinc_cnt_b - cnt0), 3);
        start = trace_b.size();
        cnt0  = rinc_cnt_b;
        wait_done("t3b", 1, 800);
        check_trace("t3b", 1, start, 40'h0405, 2);
        checkOutput("t3b_frame_len", frame_len_b, 2);
        checkOutput("t3b_rinc_cnt", 32'(rinc_cnt_b - cnt0), 2);
        enable_b = 1'b0;

        checkOutput("rinc_when_empty", 32'(empty_pop), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
